// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: triggered circular capture of execute-stage outputs, drained oldest-first over ready/valid
module exec_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_valid,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      WriteData,
    input  logic [3:0]       ALUFlags,
    input  logic             arm,
    input  logic [3:0]       trig_mask,
    input  logic [3:0]       trig_value,
    input  logic [PTR_W-1:0] post_trig,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_result,
    output logic [31:0]      rd_wdata,
    output logic [3:0]       rd_flags,
    output logic [1:0]       state,
    output logic [PTR_W:0]   count,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    state_t           state_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, post_q;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic [31:0]      res_mem [DEPTH];
    logic [31:0]      wdata_mem [DEPTH];
    logic [3:0]       flags_mem [DEPTH];
    logic             write, hit, pop;
    // capture/pop qualifiers and head-entry read-out (reads as zero when empty)
    always_comb begin
        write     = ((state_q == ARMED) || (state_q == POST)) && cap_valid;
        hit       = cap_valid && ((ALUFlags & trig_mask) == (trig_value & trig_mask));
        rd_valid  = (state_q == DONE) && (count_q != '0);
        pop       = rd_valid && rd_ready;
        rd_result = (count_q != '0) ? res_mem[rd_ptr_q] : '0;
        rd_wdata  = (count_q != '0) ? wdata_mem[rd_ptr_q] : '0;
        rd_flags  = (count_q != '0) ? flags_mem[rd_ptr_q] : '0;
        state     = state_q;
        count     = count_q;
        overflow  = overflow_q;
    end
    // sample storage; an entry is only ever read after it has been written, so no reset
    always_ff @(posedge clk) begin
        if (write) begin
            res_mem[wr_ptr_q]   <= ALUResult;
            wdata_mem[wr_ptr_q] <= WriteData;
            flags_mem[wr_ptr_q] <= ALUFlags;
        end
    end
    // capture FSM with pointer, occupancy, post-trigger and overflow bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q    <= ARMED;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                ARMED, POST: begin
                    if (write) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (count_q == FULL) begin
                            rd_ptr_q   <= rd_ptr_q + 1'b1;
                            overflow_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                        if (state_q == ARMED) begin
                            if (hit) begin
                                post_q  <= post_trig;
                                state_q <= (post_trig == '0) ? DONE : POST;
                            end
                        end else begin
                            post_q <= post_q - 1'b1;
                            if (post_q == PTR_W'(1)) state_q <= DONE;
                        end
                    end
                end
                default: begin
                    if (count_q == '0) begin
                        state_q <= IDLE;
                    end else if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        count_q  <= count_q - 1'b1;
                        if (count_q == (PTR_W+1)'(1)) state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb_exec_trace_buffer: queue-based reference model with per-cycle compare plus directed literal checks
module tb_exec_trace_buffer;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    logic             clk = 0;
    logic             reset = 1;
    logic             cap_valid = 0;
    logic [31:0]      ALUResult = 0;
    logic [31:0]      WriteData = 0;
    logic [3:0]       ALUFlags = 0;
    logic             arm = 0;
    logic [3:0]       trig_mask = 0;
    logic [3:0]       trig_value = 0;
    logic [PTR_W-1:0] post_trig = 0;
    logic             rd_valid;
    logic             rd_ready = 0;
    logic [31:0]      rd_result;
    logic [31:0]      rd_wdata;
    logic [3:0]       rd_flags;
    logic [1:0]       state;
    logic [PTR_W:0]   count;
    logic             overflow;

    exec_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .cap_valid(cap_valid), .ALUResult(ALUResult),
        .WriteData(WriteData), .ALUFlags(ALUFlags), .arm(arm), .trig_mask(trig_mask),
        .trig_value(trig_value), .post_trig(post_trig), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_result(rd_result), .rd_wdata(rd_wdata),
        .rd_flags(rd_flags), .state(state), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {logic [31:0] r; logic [31:0] w; logic [3:0] f;} ent_t;
    ent_t q[$];
    int   m_state = 0;
    bit   m_ovf = 0;
    int   m_post = 0;
    bit   started = 0;

    // reference model: the window is a queue of captured samples, oldest at the front
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_state = 0;
            m_ovf = 0;
            started = 1;
        end else begin
            case (m_state)
                0: if (arm) begin
                    q.delete();
                    m_ovf = 0;
                    m_state = 1;
                end
                1, 2: if (cap_valid) begin
                    q.push_back({ALUResult, WriteData, ALUFlags});
                    if (q.size() > DEPTH) begin
                        void'(q.pop_front());
                        m_ovf = 1;
                    end
                    if (m_state == 1) begin
                        if ((ALUFlags & trig_mask) == (trig_value & trig_mask)) begin
                            m_post = int'(post_trig) > DEPTH - 1 ? DEPTH - 1 : int'(post_trig);
                            m_state = (m_post == 0) ? 3 : 2;
                        end
                    end else begin
                        m_post--;
                        if (m_post == 0) m_state = 3;
                    end
                end
                default: begin
                    if (q.size() == 0) m_state = 0;
                    else if (rd_ready) begin
                        void'(q.pop_front());
                        if (q.size() == 0) m_state = 0;
                    end
                end
            endcase
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (started) begin
            chk("state", 64'(state), 64'(m_state));
            chk("count", 64'(count), 64'(q.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("rd_valid", 64'(rd_valid), 64'(m_state == 3 && q.size() != 0));
            chk("rd_result", 64'(rd_result), 64'(q.size() != 0 ? q[0].r : 32'd0));
            chk("rd_wdata", 64'(rd_wdata), 64'(q.size() != 0 ? q[0].w : 32'd0));
            chk("rd_flags", 64'(rd_flags), 64'(q.size() != 0 ? q[0].f : 4'd0));
        end
    end

    task automatic step(input logic cv, input int res, input logic [3:0] fl);
        @(negedge clk);
        arm = 0;
        cap_valid = cv;
        ALUResult = 32'(res);
        WriteData = 32'(res) ^ 32'hA5A5_0000;
        ALUFlags = fl;
    endtask

    task automatic do_arm(input logic [3:0] m, input logic [3:0] v, input int pt);
        @(negedge clk);
        arm = 1;
        cap_valid = 0;
        trig_mask = m;
        trig_value = v;
        post_trig = PTR_W'(pt);
    endtask

    task automatic drain_chk(input string name, input int first, input int n);
        logic [31:0] got[$];
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!rd_valid) break;
            got.push_back(rd_result);
            rd_ready = 1;
        end
        rd_ready = 0;
        chk({name, "_len"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size() && i < n; i++) chk({name, "_val"}, 64'(got[i]), 64'(first + i));
        chk({name, "_idle"}, 64'(state), 64'd0);
    endtask

    initial begin
        logic [31:0] seen[5];
        logic        pat[5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        // 1: reset, then reset during POST
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("t1_state", 64'(state), 64'd0);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_valid", 64'(rd_valid), 64'd0);
        chk("t1_ovf", 64'(overflow), 64'd0);
        do_arm(4'b0000, 4'b0000, 5);
        step(1, 1, 4'h0);
        step(1, 2, 4'h0);
        step(0, 0, 4'h0);
        chk("t1_post", 64'(state), 64'd2);
        reset = 1;
        @(negedge clk);
        chk("t1_rst_state", 64'(state), 64'd0);
        chk("t1_rst_count", 64'(count), 64'd0);
        reset = 0;
        // 2: Z-flag trigger with two post samples
        do_arm(4'b0100, 4'b0100, 2);
        for (int i = 1; i <= 7; i++) step(1, i, i == 4 ? 4'b0100 : 4'b0000);
        chk("t2_done", 64'(state), 64'd3);
        chk("t2_count", 64'(count), 64'd6);
        chk("t2_ovf", 64'(overflow), 64'd0);
        step(0, 0, 4'h0);
        drain_chk("t2_drain", 1, 6);
        // 3: wrap with overflow, trigger on sample 21, no post samples
        do_arm(4'b0010, 4'b0010, 0);
        for (int i = 1; i <= 21; i++) step(1, i, i == 21 ? 4'b0010 : 4'b0000);
        step(0, 0, 4'h0);
        chk("t3_done", 64'(state), 64'd3);
        chk("t3_count", 64'(count), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        drain_chk("t3_drain", 6, 16);
        // 4: maximal post count keeps the trigger sample
        do_arm(4'b0000, 4'b0000, 15);
        for (int i = 100; i <= 120; i++) step(1, i, 4'h0);
        step(0, 0, 4'h0);
        chk("t4_count", 64'(count), 64'd16);
        chk("t4_ovf", 64'(overflow), 64'd0);
        drain_chk("t4_drain", 100, 16);
        // 5: drain backpressure
        do_arm(4'b0000, 4'b0000, 2);
        for (int i = 50; i <= 52; i++) step(1, i, 4'h0);
        step(0, 0, 4'h0);
        chk("t5_count", 64'(count), 64'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen[i] = rd_result;
            rd_ready = pat[i];
        end
        @(negedge clk);
        rd_ready = 0;
        chk("t5_v0", 64'(seen[0]), 64'd50);
        chk("t5_v1", 64'(seen[1]), 64'd51);
        chk("t5_v2", 64'(seen[2]), 64'd51);
        chk("t5_v3", 64'(seen[3]), 64'd51);
        chk("t5_v4", 64'(seen[4]), 64'd52);
        chk("t5_state", 64'(state), 64'd0);
        chk("t5_count0", 64'(count), 64'd0);
        // 6: arm ignored outside IDLE, cap_valid gaps hold the post counter
        do_arm(4'b1111, 4'b1111, 1);
        step(1, 10, 4'h0);
        step(1, 11, 4'h0);
        @(negedge clk);
        arm = 1;
        cap_valid = 0;
        @(negedge clk);
        arm = 0;
        chk("t6_armed_state", 64'(state), 64'd1);
        chk("t6_armed_count", 64'(count), 64'd2);
        step(1, 12, 4'b1111);
        step(0, 0, 4'h0);
        step(0, 0, 4'h0);
        step(0, 0, 4'h0);
        chk("t6_gap_state", 64'(state), 64'd2);
        step(1, 13, 4'h0);
        @(negedge clk);
        cap_valid = 0;
        arm = 1;
        chk("t6_done", 64'(state), 64'd3);
        @(negedge clk);
        arm = 0;
        chk("t6_done_count", 64'(count), 64'd4);
        drain_chk("t6_drain", 10, 4);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/exec_trace_buffer.md
Name: exec_trace_buffer

Overview:
- Debug capture stage directly downstream of the processor top level.
- Samples the core's per-cycle execute outputs (ALUResult, WriteData, ALUFlags) into a circular buffer.
- Stops capture a programmable number of samples after a flag-pattern trigger, then drains the captured window oldest-first over a ready/valid read port.
- Feeds on-board debug readout and lets simulation benches check results without peeking inside the core.

Parameters:
- DEPTH, 16, number of buffer entries; power of two, minimum 4.
- PTR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high.
- cap_valid  input  1  current ALUResult/WriteData/ALUFlags sample is valid.
- ALUResult  input  32  core ALU result.
- WriteData  input  32  core store data.
- ALUFlags  input  4  core flags {N,Z,C,V}.
- arm  input  1  start a new capture; honoured in IDLE only.
- trig_mask  input  4  flag bits that participate in the trigger.
- trig_value  input  4  required value of the masked flag bits.
- post_trig  input  PTR_W  samples captured after the trigger sample.
- rd_valid  output  1  head entry available.
- rd_ready  input  1  consumer accepts the head entry.
- rd_result  output  32  head entry ALUResult.
- rd_wdata  output  32  head entry WriteData.
- rd_flags  output  4  head entry ALUFlags.
- state  output  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- count  output  PTR_W+1  entries held, 0..DEPTH.
- overflow  output  1  sticky; at least one sample overwritten since arm.

Behaviour:
Reset:
- state=IDLE; count=0; wr_ptr=rd_ptr=0; overflow=0; rd_valid=0.
- rd_result, rd_wdata and rd_flags read 0 while count=0.
- Reset overrides every other event in the same cycle, including mid-capture and mid-drain.

Trigger:
- hit = cap_valid && ((ALUFlags & trig_mask) == (trig_value & trig_mask)).
- trig_mask=0 fires on the first valid sample.

IDLE:
- No writes or reads.
- arm=1 -> ARMED next cycle; the same edge clears count, pointers and overflow.

ARMED:
- Each cycle with cap_valid=1 writes {ALUResult, WriteData, ALUFlags} at wr_ptr, and wr_ptr increments (wrap mod DEPTH).
- If count<DEPTH, count increments.
- If count==DEPTH, rd_ptr also increments (oldest dropped), count stays DEPTH, and overflow sets.
- hit -> the trigger sample is written as above; post counter loads min(post_trig, DEPTH-1).
  - Loaded value 0 -> DONE.
  - Otherwise -> POST.

POST:
- Same write/overwrite rules as ARMED.
- Each written sample decrements the post counter; the write that takes it to 0 moves to DONE next cycle.
- cap_valid=0 cycles do not decrement.
- Clipping to DEPTH-1 guarantees the trigger sample is never overwritten.

DONE:
- Capture ignored.
- rd_valid = (count!=0).
- rd_* show the entry at rd_ptr combinationally from storage.
- rd_valid && rd_ready pops: rd_ptr increments and count decrements.
- rd_valid may not drop without a pop while count!=0.
- The pop that makes count 0 -> IDLE next cycle. DONE with count 0 (unreachable, since the trigger sample is always present) also -> IDLE.

General:
- arm outside IDLE is ignored.
- rd_ready outside DONE is ignored.
- Read port latency: 0 cycles; a pop is visible as new rd_* the cycle after the accepting edge.
- Throughput: one sample written per cycle, one pop per cycle.

Test Plan:
1. Reset held 3 cycles, then released -> state=0, count=0, rd_valid=0, overflow=0. Asserting reset=1 during POST -> state=0, count=0 next cycle.
2. arm, trig_mask=4'b0100, trig_value=4'b0100, post_trig=2. Feed ALUResult 1,2,3 with Z=0, then 4 with Z=1, then 5,6,7. Response:
   - DONE after sample 6.
   - count=6, overflow=0.
   - Drain with rd_ready=1 yields 1,2,3,4,5,6, then IDLE.
   - Sample 7 is not captured.
3. arm, trig_mask=4'b0010, no hit for 20 samples (ALUResult 1..20), then hit on 21, post_trig=0. Response:
   - DONE the cycle after 21.
   - count=16, overflow=1.
   - Drain yields 6..21.
4. post_trig=15, trig_mask=0, first sample 100, then 101..120. Response:
   - Post count clipped to 15; DONE after 115.
   - Drain yields 100..115 and includes the trigger sample.
5. Drain backpressure: in DONE with count=3, rd_ready toggles 1,0,0,1,1. Response:
   - rd_result is stable while rd_ready=0.
   - Exactly three pops; state returns to IDLE on the following cycle.
6. arm asserted during ARMED and during DONE -> no effect on count or pointers. cap_valid=0 gaps in POST -> post counter holds.
